// File: rtl/alu_iter.sv
// alu_iter: handshaked execute unit for RV64I/RV64M (or RV32 when XLEN=32).
// One operation is in flight at a time. Single-cycle integer ops, radix-2
// shift-add multiply and restoring divide all return a registered result
// together with the tag captured at accept.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               abort the in-flight or held operation
//   in_valid/in_ready   request handshake (in_ready only while idle)
//   in_op, in_word      operation code and 32-bit W-form select
//   in_src1, in_src2    operands
//   in_tag              opaque tag carried to out_tag
//   out_valid/out_ready result handshake; outputs hold while stalled
//   out_res, out_zero   result and (result == 0)
//   out_tag             tag captured with the request
module alu_iter #(
   parameter int XLEN  = 64,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       in_op,
   input  logic             in_word,
   input  logic [XLEN-1:0]  in_src1,
   input  logic [XLEN-1:0]  in_src2,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_res,
   output logic             out_zero,
   output logic [TAG_W-1:0] out_tag
);

   localparam int SH_W  = $clog2(XLEN);
   localparam int CNT_W = $clog2(XLEN);

   localparam logic [4:0] OP_ADD    = 5'd0;
   localparam logic [4:0] OP_SUB    = 5'd1;
   localparam logic [4:0] OP_SLL    = 5'd2;
   localparam logic [4:0] OP_SLT    = 5'd3;
   localparam logic [4:0] OP_SLTU   = 5'd4;
   localparam logic [4:0] OP_XOR    = 5'd5;
   localparam logic [4:0] OP_SRL    = 5'd6;
   localparam logic [4:0] OP_SRA    = 5'd7;
   localparam logic [4:0] OP_OR     = 5'd8;
   localparam logic [4:0] OP_AND    = 5'd9;
   localparam logic [4:0] OP_MUL    = 5'd10;
   localparam logic [4:0] OP_MULH   = 5'd11;
   localparam logic [4:0] OP_MULHSU = 5'd12;
   localparam logic [4:0] OP_MULHU  = 5'd13;
   localparam logic [4:0] OP_DIV    = 5'd14;
   localparam logic [4:0] OP_DIVU   = 5'd15;
   localparam logic [4:0] OP_REM    = 5'd16;
   localparam logic [4:0] OP_REMU   = 5'd17;

   // Most-negative dividend, full width and sign-extended 32-bit form.
   localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] MIN_W = {{(XLEN-31){1'b1}}, {31{1'b0}}};

   // EXEC is a decode/setup cycle between accept and the result or the
   // first iteration; it gives single-cycle ops their one-edge latency.
   typedef enum logic [2:0] {S_IDLE, S_EXEC, S_MUL, S_DIV, S_DONE} state_t;

   function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
      logic [XLEN-1:0] r;
      r = v;
      for (int i = 32; i < XLEN; i++) r[i] = v[31];
      return r;
   endfunction

   function automatic logic [XLEN-1:0] zext32(input logic [XLEN-1:0] v);
      logic [XLEN-1:0] r;
      r = v;
      for (int i = 32; i < XLEN; i++) r[i] = 1'b0;
      return r;
   endfunction

   state_t              state_q, state_d;
   logic [4:0]          op_q, op_d;
   logic                word_q, word_d;
   logic [XLEN-1:0]     src1_q, src1_d, src2_q, src2_d;
   logic [TAG_W-1:0]    tag_q, tag_d;
   logic [XLEN-1:0]     res_q, res_d;
   logic                zero_q, zero_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [XLEN-1:0]     mcand_q, mcand_d;
   logic [2*XLEN-1:0]   prod_q, prod_d;
   logic                mneg_q, mneg_d;
   logic [XLEN-1:0]     dsr_q, dsr_d, dvd_q, dvd_d, rem_q, rem_d;
   logic                qneg_q, qneg_d, rneg_q, rneg_d;

   // Single-cycle ALU
   logic [XLEN-1:0]     a_s, a_z, b_s, b_z, alu_raw, alu_fin;
   logic [SH_W-1:0]     shamt;
   // Multiplier setup and step
   logic                is_mul, mul_s1, mul_s2;
   logic [XLEN-1:0]     mul_a, mul_b, mul_res;
   logic [XLEN:0]       mul_sum;
   logic [2*XLEN-1:0]   prod_nx, prod_sgn;
   // Divider setup and step
   logic                is_div, div_sgn, div_rem, d1_n, d2_n, div_dz, div_ovf;
   logic [XLEN-1:0]     d1_e, d2_e, d1_mag, d2_mag, div_sp, div_res;
   logic [XLEN-1:0]     rem_nx, dvd_nx, q_fin, r_fin;
   logic [XLEN:0]       div_sh, div_df;
   logic                div_qb;
   // Result load
   logic                load_res;
   logic [XLEN-1:0]     fin_res;

   always_comb begin
      a_s   = word_q ? sext32(src1_q) : src1_q;
      a_z   = word_q ? zext32(src1_q) : src1_q;
      b_s   = word_q ? sext32(src2_q) : src2_q;
      b_z   = word_q ? zext32(src2_q) : src2_q;
      shamt = word_q ? SH_W'(src2_q[4:0]) : src2_q[SH_W-1:0];
      alu_raw = a_s + b_s;
      case (op_q)
         OP_SUB:  alu_raw = a_s - b_s;
         OP_SLL:  alu_raw = src1_q << shamt;
         OP_SLT:  alu_raw = XLEN'($signed(a_s) < $signed(b_s));
         OP_SLTU: alu_raw = XLEN'(a_z < b_z);
         OP_XOR:  alu_raw = src1_q ^ src2_q;
         // Word SRL/SRA shift the zero/sign-extended low word.
         OP_SRL:  alu_raw = a_z >> shamt;
         OP_SRA:  alu_raw = $signed(a_s) >>> shamt;
         OP_OR:   alu_raw = src1_q | src2_q;
         OP_AND:  alu_raw = src1_q & src2_q;
         default: ;
      endcase
      alu_fin = word_q ? sext32(alu_raw) : alu_raw;
   end

   always_comb begin
      is_mul = (op_q >= OP_MUL) && (op_q <= OP_MULHU);
      // Signed operands only matter for the high-half forms; word MULH*
      // degrade to a plain low-word multiply.
      mul_s1 = !word_q && ((op_q == OP_MULH) || (op_q == OP_MULHSU)) && src1_q[XLEN-1];
      mul_s2 = !word_q && (op_q == OP_MULH) && src2_q[XLEN-1];
      mul_a  = word_q ? zext32(src1_q) : (mul_s1 ? -src1_q : src1_q);
      mul_b  = word_q ? zext32(src2_q) : (mul_s2 ? -src2_q : src2_q);

      // Upper half accumulates, lower half holds the remaining multiplier bits.
      mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
      prod_nx  = {mul_sum, prod_q[XLEN-1:1]};
      prod_sgn = mneg_q ? -prod_nx : prod_nx;
      if (word_q)
         // After 32 steps the low-word product sits just below the midpoint.
         mul_res = sext32(prod_nx[XLEN-1:0] >> (XLEN-32));
      else if (op_q == OP_MUL)
         mul_res = prod_sgn[XLEN-1:0];
      else
         mul_res = prod_sgn[2*XLEN-1:XLEN];
   end

   always_comb begin
      is_div  = (op_q >= OP_DIV);
      div_sgn = (op_q == OP_DIV) || (op_q == OP_REM);
      div_rem = (op_q == OP_REM) || (op_q == OP_REMU);
      d1_e    = word_q ? (div_sgn ? sext32(src1_q) : zext32(src1_q)) : src1_q;
      d2_e    = word_q ? (div_sgn ? sext32(src2_q) : zext32(src2_q)) : src2_q;
      d1_n    = div_sgn && d1_e[XLEN-1];
      d2_n    = div_sgn && d2_e[XLEN-1];
      d1_mag  = d1_n ? -d1_e : d1_e;
      d2_mag  = d2_n ? -d2_e : d2_e;
      div_dz  = (d2_e == '0);
      div_ovf = div_sgn && (d2_e == '1) && (d1_e == (word_q ? MIN_W : MIN_X));
      if (div_dz)
         div_sp = div_rem ? d1_e : '1;
      else
         div_sp = div_rem ? '0 : d1_e;

      // Dividend bits leave at the top of dvd while quotient bits enter at the bottom.
      div_sh = {rem_q, dvd_q[XLEN-1]};
      div_df = div_sh - {1'b0, dsr_q};
      div_qb = !div_df[XLEN];
      rem_nx = div_qb ? div_df[XLEN-1:0] : div_sh[XLEN-1:0];
      dvd_nx = {dvd_q[XLEN-2:0], div_qb};
      q_fin  = qneg_q ? -dvd_nx : dvd_nx;
      r_fin  = rneg_q ? -rem_nx : rem_nx;
      div_res = div_rem ? r_fin : q_fin;
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      word_d   = word_q;
      src1_d   = src1_q;
      src2_d   = src2_q;
      tag_d    = tag_q;
      res_d    = res_q;
      zero_d   = zero_q;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      prod_d   = prod_q;
      mneg_d   = mneg_q;
      dsr_d    = dsr_q;
      dvd_d    = dvd_q;
      rem_d    = rem_q;
      qneg_d   = qneg_q;
      rneg_d   = rneg_q;
      load_res = 1'b0;
      fin_res  = '0;
      case (state_q)
         S_IDLE: begin
            if (in_valid && !flush) begin
               op_d    = (in_op > OP_REMU) ? OP_ADD : in_op;
               word_d  = (XLEN == 64) ? in_word : 1'b0;
               src1_d  = in_src1;
               src2_d  = in_src2;
               tag_d   = in_tag;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            cnt_d = word_q ? CNT_W'(31) : CNT_W'(XLEN-1);
            if (is_mul) begin
               mcand_d = mul_a;
               prod_d  = {{XLEN{1'b0}}, mul_b};
               mneg_d  = mul_s1 ^ mul_s2;
               state_d = S_MUL;
            end else if (is_div) begin
               if (div_dz || div_ovf) begin
                  fin_res  = word_q ? sext32(div_sp) : div_sp;
                  load_res = 1'b1;
                  state_d  = S_DONE;
               end else begin
                  dvd_d   = word_q ? (d1_mag << (XLEN-32)) : d1_mag;
                  dsr_d   = d2_mag;
                  rem_d   = '0;
                  qneg_d  = d1_n ^ d2_n;
                  rneg_d  = d1_n;
                  state_d = S_DIV;
               end
            end else begin
               fin_res  = alu_fin;
               load_res = 1'b1;
               state_d  = S_DONE;
            end
         end
         S_MUL: begin
            prod_d = prod_nx;
            if (cnt_q == '0) begin
               fin_res  = mul_res;
               load_res = 1'b1;
               state_d  = S_DONE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_DIV: begin
            rem_d = rem_nx;
            dvd_d = dvd_nx;
            if (cnt_q == '0) begin
               fin_res  = word_q ? sext32(div_res) : div_res;
               load_res = 1'b1;
               state_d  = S_DONE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (load_res && !flush) begin
         res_d  = fin_res;
         zero_d = (fin_res == '0);
      end
      if (flush) state_d = S_IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         word_q  <= 1'b0;
         src1_q  <= '0;
         src2_q  <= '0;
         tag_q   <= '0;
         res_q   <= '0;
         zero_q  <= 1'b0;
         cnt_q   <= '0;
         mcand_q <= '0;
         prod_q  <= '0;
         mneg_q  <= 1'b0;
         dsr_q   <= '0;
         dvd_q   <= '0;
         rem_q   <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         word_q  <= word_d;
         src1_q  <= src1_d;
         src2_q  <= src2_d;
         tag_q   <= tag_d;
         res_q   <= res_d;
         zero_q  <= zero_d;
         cnt_q   <= cnt_d;
         mcand_q <= mcand_d;
         prod_q  <= prod_d;
         mneg_q  <= mneg_d;
         dsr_q   <= dsr_d;
         dvd_q   <= dvd_d;
         rem_q   <= rem_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign out_res   = res_q;
   assign out_zero  = zero_q;
   assign out_tag   = tag_q;

endmodule
